// File: rtl/sensor_adc_pkg.sv
// Shared types and constants for the XADC sampling sequencer.
//   state_t          : sequencer FSM encoding
//   CH_BASE          : DRP address of XADC VAUX0 status; channel n reads CH_BASE+n
//   XADC_CODE_W      : width of one conversion code (drp_do[15:4])
//   DRDY_TIMEOUT_DFLT: default cycles allowed for a DRP read to answer
package sensor_adc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    SELECT    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DRDY = 3'd4,
    PUBLISH   = 3'd5
  } state_t;

  localparam logic [6:0] CH_BASE           = 7'h10;
  localparam int         XADC_CODE_W       = 12;
  localparam int         DRDY_TIMEOUT_DFLT = 64;

endpackage

// File: rtl/sensor_adc_period_timer.sv
// Start-to-start scan period timer.
//   clock, reset : system clock, synchronous active-high reset
//   i_clr        : synchronous clear, asserted on the cycle a scan starts
//   i_period     : requested cycles between scan starts (0 = always due)
//   o_tick       : a new scan is due
module sensor_adc_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_clr,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_cnt;

  // The clearing cycle is itself the first cycle of the new period, so the
  // counter restarts at 1 and a tick falls exactly i_period cycles later.
  // The count saturates so an overlong scan can never wrap and lose a tick.
  always_ff @(posedge clock) begin
    if (reset)             r_cnt <= '0;
    else if (i_clr)        r_cnt <= PERIOD_W'(1);
    else if (r_cnt != '1)  r_cnt <= r_cnt + PERIOD_W'(1);
  end

  assign o_tick = (r_cnt >= i_period);

endmodule

// File: rtl/sensor_adc_sampler.sv
// XADC DRP sampling sequencer behind the myip_sensor_adc register slice.
// Each period it scans the enabled aux channels, averages 2^AVG_LOG2 DRP
// reads per channel and strobes one result per channel back to the slice.
//   clock, reset        : system clock, synchronous active-high reset
//   cfg_enable/ch_mask/period/err_clr : control registers from the slice
//   drp_den/daddr/dwe   : DRP read request (one-cycle den per read)
//   drp_drdy/drp_do     : DRP read response, code in drp_do[15:4]
//   res_valid/ch/data   : one-cycle averaged result strobe
//   busy                : a scan is in progress
//   err_timeout         : sticky DRDY timeout flag
module sensor_adc_sampler
  import sensor_adc_pkg::*;
#(
  parameter int CH_NUM       = 4,
  parameter int AVG_LOG2     = 3,
  parameter int PERIOD_W     = 16,
  parameter int DRDY_TIMEOUT = DRDY_TIMEOUT_DFLT,
  localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_enable,
  input  logic [CH_NUM-1:0]   cfg_ch_mask,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_err_clr,
  output logic                drp_den,
  output logic [6:0]          drp_daddr,
  output logic                drp_dwe,
  input  logic                drp_drdy,
  input  logic [15:0]         drp_do,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [11:0]         res_data,
  output logic                busy,
  output logic                err_timeout
);

  localparam int               ACC_W   = XADC_CODE_W + AVG_LOG2;
  localparam int               WAIT_W  = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [AVG_LOG2:0] LAST_RD = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  localparam logic [AVG_LOG2:0] CNT_ONE = (AVG_LOG2 + 1)'(1);

  state_t                  r_state;
  logic [CH_NUM-1:0]       r_pend;
  logic [CH_W-1:0]         r_ch;
  logic [ACC_W-1:0]        r_acc;
  logic [AVG_LOG2:0]       r_cnt;
  logic [WAIT_W-1:0]       r_wait;
  logic                    r_res_valid;
  logic [CH_W-1:0]         r_res_ch;
  logic [11:0]             r_res_data;
  logic                    r_err;

  logic                    w_tick;
  logic                    w_cfg_ok;
  logic                    w_scan_go;
  logic                    w_tmr_clr;
  logic                    w_found;
  logic [CH_W-1:0]         w_sel;
  logic                    w_timeout;
  logic                    w_issue;
  logic [XADC_CODE_W-1:0]  w_code;
  logic                    w_unused_do;

  assign w_code      = drp_do[15:4];
  assign w_unused_do = ^drp_do[3:0];

  // Lowest pending channel of the latched mask.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(i);
      end
    end
  end

  assign w_cfg_ok  = cfg_enable && (cfg_ch_mask != '0);
  // A scan starts from WAIT_TICK, or straight out of SELECT when the previous
  // scan overran the period, so back-to-back scans never pass through WAIT_TICK.
  assign w_scan_go = w_cfg_ok && w_tick &&
                     ((r_state == WAIT_TICK) || ((r_state == SELECT) && !w_found));
  assign w_tmr_clr = (r_state == IDLE) || w_scan_go;

  // r_wait counts cycles since den (the den cycle is 1), so the read is
  // abandoned DRDY_TIMEOUT cycles after den; drdy on that last cycle still wins.
  assign w_timeout = (r_state == WAIT_DRDY) && !drp_drdy &&
                     (r_wait == WAIT_W'(DRDY_TIMEOUT - 1));

  sensor_adc_period_timer #(.PERIOD_W(PERIOD_W)) u_tmr (
    .clock    (clock),
    .reset    (reset),
    .i_clr    (w_tmr_clr),
    .i_period (cfg_period),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_ch        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_timeout)        r_err <= 1'b1;
      else if (cfg_err_clr) r_err <= 1'b0;

      case (r_state)
        IDLE: if (w_cfg_ok) r_state <= WAIT_TICK;
        WAIT_TICK: begin
          if (!w_cfg_ok) r_state <= IDLE;
          else if (w_tick) begin
            r_pend  <= cfg_ch_mask;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          if (!cfg_enable) r_state <= IDLE;
          else if (w_found) begin
            r_ch          <= w_sel;
            r_pend[w_sel] <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_state       <= ISSUE;
          end else if (w_scan_go) r_pend <= cfg_ch_mask;
          else r_state <= WAIT_TICK;
        end
        ISSUE: begin
          r_wait  <= WAIT_W'(1);
          r_state <= WAIT_DRDY;
        end
        WAIT_DRDY: begin
          if (drp_drdy) begin
            if (!cfg_enable) begin
              // disabled mid-read: the read has landed, drop the channel
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_acc   <= r_acc + ACC_W'(w_code);
              r_cnt   <= r_cnt + CNT_ONE;
              r_state <= (r_cnt == LAST_RD) ? PUBLISH : ISSUE;
            end
          end else if (w_timeout) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= SELECT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        PUBLISH: begin
          r_res_valid <= 1'b1;
          r_res_ch    <= r_ch;
          r_res_data  <= r_acc[ACC_W-1:AVG_LOG2];
          r_acc       <= '0;
          r_cnt       <= '0;
          r_state     <= SELECT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_issue     = (r_state == ISSUE);
  assign drp_den     = w_issue;
  assign drp_daddr   = w_issue ? (CH_BASE + 7'(r_ch)) : 7'h00;
  assign drp_dwe     = 1'b0;
  assign res_valid   = r_res_valid;
  assign res_ch      = r_res_ch;
  assign res_data    = r_res_data;
  assign busy        = (r_state != IDLE) && (r_state != WAIT_TICK);
  assign err_timeout = r_err;

endmodule

// File: tb/tb_sensor_adc_sampler.sv
module tb_sensor_adc_sampler;

  logic        clock, reset;
  logic        cfg_enable, cfg_err_clr;
  logic [3:0]  cfg_ch_mask;
  logic [15:0] cfg_period;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_do;
  logic        res_valid, busy, err_timeout;
  logic [1:0]  res_ch;
  logic [11:0] res_data;

  sensor_adc_sampler dut (
    .clock(clock), .reset(reset),
    .cfg_enable(cfg_enable), .cfg_ch_mask(cfg_ch_mask), .cfg_period(cfg_period),
    .cfg_err_clr(cfg_err_clr),
    .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_dwe(drp_dwe),
    .drp_drdy(drp_drdy), .drp_do(drp_do),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct { int ch; int data; } exp_t;
  exp_t sb[$];

  // ---------------- cycle counter ----------------
  int cyc = 0;
  initial forever begin @(posedge clock); cyc++; end

  // ---------------- DRP model ----------------
  int          m_lat = 3, m_mode = 0, m_mute = -1;
  logic [11:0] m_code = 12'hABC;
  int          m_cnt[8], m_sum[8];
  int          m_cd = -1, m_addr = 0;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin m_cnt[i] = 0; m_sum[i] = 0; end
    m_cd = -1;
  endtask

  initial begin
    logic [11:0] c;
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    model_clear();
    forever begin
      @(negedge clock);
      drp_drdy = 1'b0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          c = (m_mode != 0) ? m_code + 12'(m_cnt[m_addr]) : m_code;
          drp_do   = {c, 4'h9};
          drp_drdy = 1'b1;
          m_sum[m_addr] += int'(c);
          m_cnt[m_addr]++;
          if (m_cnt[m_addr] == 8) begin
            sb.push_back('{m_addr, m_sum[m_addr] >> 3});
            m_cnt[m_addr] = 0;
            m_sum[m_addr] = 0;
          end
          m_cd = -1;
        end
      end
      if (drp_den) begin
        m_addr = (int'(drp_daddr) - 16) & 7;
        if (m_addr != m_mute) m_cd = m_lat;
      end
    end
  end

  // ---------------- monitor ----------------
  int   n_den = 0, n_busy = 0, n_res = 0, n_res0 = 0;
  int   den0_cyc = -1, err_rise = -1;
  int   rise_cyc[$], rise_nbusy[$], rise_nden[$];
  int   res_cyc_q[$], res_ch_q[$], res_dat_q[$];
  logic busy_q = 1'b0, err_q = 1'b0;

  task automatic clr_mon();
    rise_cyc.delete(); rise_nbusy.delete(); rise_nden.delete();
    res_cyc_q.delete(); res_ch_q.delete(); res_dat_q.delete();
    n_res = 0; n_res0 = 0; den0_cyc = -1; err_rise = -1;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clock);
    if (busy && !busy_q) begin
      rise_cyc.push_back(cyc);
      rise_nbusy.push_back(n_busy);
      rise_nden.push_back(n_den);
    end
    busy_q = busy;
    if (busy) n_busy++;
    if (drp_den) begin
      n_den++;
      if (drp_daddr == 7'h10 && den0_cyc < 0) den0_cyc = cyc;
    end
    if (err_timeout && !err_q) err_rise = cyc;
    err_q = err_timeout;
    if (res_valid) begin
      n_res++;
      if (res_ch == 2'd0) n_res0++;
      res_cyc_q.push_back(cyc);
      res_ch_q.push_back(int'(res_ch));
      res_dat_q.push_back(int'(res_data));
      chk("sb_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_ch", int'(res_ch), e.ch);
        chk("sb_data", int'(res_data), e.data);
      end
    end
  end

  task automatic tk(input int n = 1);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d;
    reset = 1'b1; cfg_enable = 1'b0; cfg_err_clr = 1'b0;
    cfg_ch_mask = 4'b0; cfg_period = 16'd0;
    tk(3);
    chk("rst_den", drp_den, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_dwe", drp_dwe, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    reset = 1'b0;
    tk(2);

    // 1: constant code, channels 0 and 2, period 1000
    clr_mon(); m_lat = 3; m_mode = 0; m_code = 12'hABC; m_mute = -1;
    cfg_period = 16'd1000; cfg_ch_mask = 4'b0101; cfg_enable = 1'b1;
    for (int k = 0; k < 3000 && rise_cyc.size() < 2; k++) tk();
    chk("t1_two_scans", int'(rise_cyc.size() >= 2), 1);
    chk("t1_period", qat(rise_cyc, 1) - qat(rise_cyc, 0), 1000);
    chk("t1_den_per_scan", qat(rise_nden, 1) - qat(rise_nden, 0), 16);
    chk("t1_busy_cycles", qat(rise_nbusy, 1) - qat(rise_nbusy, 0), 69);
    chk("t1_first_latency", qat(res_cyc_q, 0) - qat(rise_cyc, 0), 34);
    chk("t1_res_per_scan", n_res, 2);
    chk("t1_ch_first", qat(res_ch_q, 0), 0);
    chk("t1_ch_second", qat(res_ch_q, 1), 2);
    chk("t1_data", qat(res_dat_q, 1), 12'hABC);
    for (int k = 0; k < 300 && !(n_res >= 4 && !busy); k++) tk();
    chk("t1_scan2_done", n_res, 4);
    cfg_enable = 1'b0;
    tk(4);
    chk("t1_sb_drained", sb.size(), 0);
    chk("t1_busy_off", busy, 0);

    // 2: ramping codes 0x100..0x107 on channel 1
    clr_mon(); model_clear(); m_mode = 1; m_code = 12'h100;
    cfg_period = 16'd2000; cfg_ch_mask = 4'b0010; cfg_enable = 1'b1;
    for (int k = 0; k < 3000 && n_res < 1; k++) tk();
    cfg_enable = 1'b0;
    chk("t2_got_result", int'(n_res >= 1), 1);
    chk("t2_ch", qat(res_ch_q, 0), 1);
    chk("t2_avg", qat(res_dat_q, 0), 12'h103);
    tk(5);
    chk("t2_sb_drained", sb.size(), 0);

    // 3: channel 0 never answers
    clr_mon(); model_clear(); m_mode = 0; m_code = 12'hABC; m_mute = 0;
    cfg_period = 16'd2000; cfg_ch_mask = 4'b0011; cfg_enable = 1'b1;
    for (int k = 0; k < 3000 && n_res < 1; k++) tk();
    cfg_enable = 1'b0;
    chk("t3_err_set", err_timeout, 1);
    chk("t3_err_latency", err_rise - den0_cyc, 64);
    chk("t3_no_ch0", n_res0, 0);
    chk("t3_ch1", qat(res_ch_q, 0), 1);
    tk(3);
    chk("t3_err_sticky", err_timeout, 1);
    cfg_err_clr = 1'b1; tk(); cfg_err_clr = 1'b0;
    chk("t3_err_clr", err_timeout, 0);
    m_mute = -1;
    chk("t3_sb_drained", sb.size(), 0);

    // 4: back-to-back scans of all channels
    clr_mon(); model_clear();
    cfg_period = 16'd0; cfg_ch_mask = 4'b1111; cfg_enable = 1'b1;
    for (int k = 0; k < 2000 && n_res < 6; k++) tk();
    cfg_enable = 1'b0;
    chk("t4_got_six", int'(n_res >= 6), 1);
    for (int i = 0; i < 6; i++) chk("t4_ch_seq", qat(res_ch_q, i), i % 4);
    chk("t4_gap", qat(res_cyc_q, 1) - qat(res_cyc_q, 0), 34);
    chk("t4_wrap_gap", qat(res_cyc_q, 4) - qat(res_cyc_q, 3), 35);
    chk("t4_single_busy", rise_cyc.size(), 1);
    tk(10);
    chk("t4_busy_off", busy, 0);
    chk("t4_sb_drained", sb.size(), 0);

    // 5: enable dropped while channel 1 read is outstanding
    clr_mon(); model_clear(); m_code = 12'h555;
    cfg_period = 16'd2000; cfg_ch_mask = 4'b0011; cfg_enable = 1'b1;
    for (int k = 0; k < 3000 && !(drp_den && drp_daddr == 7'h11); k++) tk();
    chk("t5_ch1_den", int'(drp_den && drp_daddr == 7'h11), 1);
    cfg_enable = 1'b0;
    d = n_den;
    tk(20);
    chk("t5_no_more_den", n_den - d, 0);
    chk("t5_only_ch0", n_res, 1);
    chk("t5_ch0", qat(res_ch_q, 0), 0);
    chk("t5_ch0_data", qat(res_dat_q, 0), 12'h555);
    chk("t5_busy_off", busy, 0);
    chk("t5_sb_drained", sb.size(), 0);

    // 6: reset during a read, late drdy afterwards
    clr_mon(); model_clear(); m_code = 12'hABC;
    cfg_period = 16'd2000; cfg_ch_mask = 4'b0001; cfg_enable = 1'b1;
    for (int k = 0; k < 3000 && !drp_den; k++) tk();
    chk("t6_den_seen", drp_den, 1);
    tk();
    reset = 1'b1; cfg_enable = 1'b0;
    tk();
    reset = 1'b0;
    d = n_den;
    tk(10);
    chk("t6_no_res", n_res, 0);
    chk("t6_no_den", n_den - d, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rdata_rst", res_data, 0);
    chk("t6_err", err_timeout, 0);
    model_clear(); sb.delete();
    cfg_period = 16'd100; cfg_enable = 1'b1;
    for (int k = 0; k < 1000 && n_res < 1; k++) tk();
    cfg_enable = 1'b0;
    chk("t6_restart_res", n_res, 1);
    chk("t6_restart_data", qat(res_dat_q, 0), 12'hABC);
    tk(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_adc_sampler.md
Name: sensor_adc_sampler

Overview:
Sequencer that sits directly downstream of the myip_sensor_adc AXI4-Lite register slice.
- Consumes its control registers (enable, channel mask, sample period).
- Periodically reads the selected channels of the on-chip XADC over its DRP port.
- Averages 2^AVG_LOG2 conversions per channel and publishes one result per channel as a single-cycle strobe back into the register slice's status/result registers.

Parameters:
CH_NUM, 4, number of auxiliary channels scanned (channel index width = clog2(CH_NUM)).
AVG_LOG2, 3, log2 of reads averaged per channel (8 reads).
PERIOD_W, 16, width of cfg_period.
DRDY_TIMEOUT, 64, cycles to wait for drp_drdy before aborting a read.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_enable  in  1  run enable (level)
cfg_ch_mask  in  CH_NUM  bit n = scan channel n
cfg_period  in  PERIOD_W  cycles between scan starts; 0 = back-to-back
cfg_err_clr  in  1  pulse, clears err_timeout
drp_den  out  1  DRP enable, one-cycle pulse per read
drp_daddr  out  7  DRP address = CH_BASE + channel
drp_dwe  out  1  tied 0 (read-only)
drp_drdy  in  1  DRP read data valid
drp_do  in  16  DRP read data; conversion code in [15:4]
res_valid  out  1  one-cycle result strobe
res_ch  out  clog2(CH_NUM)  channel of res_data
res_data  out  12  averaged 12-bit code
busy  out  1  high from scan start to scan end
err_timeout  out  1  sticky DRDY timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; timer, accumulator and read counter 0.
- States:
  - IDLE: wait for cfg_enable=1 and cfg_ch_mask!=0, then WAIT_TICK.
  - WAIT_TICK: timer counts up. When timer reaches cfg_period (or immediately if cfg_period=0), latch mask and period, clear timer, go SELECT.
  - SELECT: pick the lowest set bit of the latched mask not yet scanned. If none remain, go WAIT_TICK (or IDLE if cfg_enable=0).
  - ISSUE: drive drp_den=1 for exactly one cycle with drp_daddr, then WAIT_DRDY.
  - WAIT_DRDY:
    - On drp_drdy: add drp_do[15:4] to the accumulator and increment the read count.
    - If the count is below 2^AVG_LOG2, go ISSUE; otherwise go PUBLISH.
    - If DRDY_TIMEOUT cycles elapse without drdy: set err_timeout, discard the accumulator, mark the channel done without publishing, go SELECT.
  - PUBLISH: res_valid=1 for one cycle with res_ch and res_data = accumulator >> AVG_LOG2; clear the accumulator; go SELECT.
- Accumulator width is 12+AVG_LOG2 bits; no overflow possible; truncating division.
- The timer runs during the scan: the period is measured start-to-start. If a scan outlasts cfg_period, the next scan starts immediately after SELECT finds no channel; ticks are not queued.
- busy=1 in every state except IDLE and WAIT_TICK.
- cfg_* changes mid-scan take effect at the next tick; the latched copies are used within a scan.
- cfg_enable dropping mid-scan:
  - An outstanding DRP read completes (drdy or timeout) and no further reads are issued.
  - The current channel is not published; go IDLE.
- drp_drdy outside WAIT_DRDY is ignored.
- err_timeout: set by a timeout and cleared by cfg_err_clr. If both occur in the same cycle, set wins.
- Reset asserted mid-transaction returns to IDLE next cycle. A late drdy after reset is ignored.
- Latency with a DRP that answers in L cycles: first res_valid arrives 2 + 2^AVG_LOG2 × (L+1) + 1 cycles after the tick.

Decomposition:
- Package sensor_adc_pkg:
  - state_t enum (IDLE, WAIT_TICK, SELECT, ISSUE, WAIT_DRDY, PUBLISH)
  - CH_BASE = 7'h10 (XADC VAUX0 status address)
  - XADC_CODE_W = 12
  - default DRDY_TIMEOUT
- One sub-module, sensor_adc_period_timer: free-running start-to-start counter with a tick output and a synchronous clear.
- Channel select, DRP handshake and accumulator stay in the top FSM.

Test Plan:
1. DRP model returns 16'hABC0 with 3-cycle latency; mask 4'b0101; period 1000 -> per period two res_valid strobes, ch0 then ch2, res_data=12'hABC; 16 drp_den pulses per scan; busy low between scans.
2. Model returns codes 12'h100..12'h107 sequentially for ch1 (mask 4'b0010) -> res_data=12'h103, res_ch=1.
3. Model never asserts drdy for ch0; mask 4'b0011 -> err_timeout rises 64 cycles after the first ch0 den; no ch0 result; ch1 still published; cfg_err_clr clears the flag.
4. cfg_period=0, mask 4'b1111 -> scans back-to-back; res_ch sequence 0,1,2,3,0,... with no WAIT_TICK idle cycles.
5. cfg_enable dropped during ch1 WAIT_DRDY -> one pending drdy accepted, no further den, no ch1 result, state IDLE, busy=0.
6. reset pulsed during WAIT_DRDY, then drdy arrives -> all outputs 0, no res_valid, restart only after re-enable.
